// File: rtl/mem_arbiter.sv
// mem_arbiter
// Serialises the instruction-fetch port and the data port of the request
// unit onto a single RAM port. Data requests win a tie unless the previous
// grant also went to data, which keeps fetch from starving behind a stream
// of loads/stores. Each completed access returns a one-cycle ihit/dhit pulse
// with the load data. A watchdog raises a sticky err when the RAM sits on an
// access for TIMEOUT cycles without answering.
//
// Ports:
//   clk, nrst            clock (rising edge), asynchronous active-high reset
//   imemren/imemaddr     fetch request (held until ihit) and its address
//   imemload/ihit        fetched word and its one-cycle completion pulse
//   dmemren/dmemwen      data read / write request (held until dhit)
//   dmemaddr/dmemstore   data address and write data
//   dmemload/dhit        read data and its one-cycle completion pulse
//   ram_ren/ram_wen      RAM read / write strobes (registered)
//   ram_addr/ram_store   RAM address and write data (registered)
//   ram_load/ram_ready   RAM read data, valid in the cycle ram_ready is high
//   err                  sticky RAM timeout flag
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              imemren,
    input  logic [ADDR_W-1:0] imemaddr,
    output logic [DATA_W-1:0] imemload,
    output logic              ihit,
    input  logic              dmemren,
    input  logic              dmemwen,
    input  logic [ADDR_W-1:0] dmemaddr,
    input  logic [DATA_W-1:0] dmemstore,
    output logic [DATA_W-1:0] dmemload,
    output logic              dhit,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_store,
    input  logic [DATA_W-1:0] ram_load,
    input  logic              ram_ready,
    output logic              err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HIT  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic               dreq;
    logic               any_req;
    logic               grant_d;
    logic               src_d;     // access in flight belongs to the data side
    logic               src_wr;    // access in flight is a write
    logic               last_d;    // previous grant went to the data side
    logic [CNT_W-1:0]   wd_cnt;

    // Grant decision, only acted on in IDLE. A simultaneous read+write
    // request is handled as a write further down.
    always_comb begin
        dreq    = dmemren | dmemwen;
        any_req = dreq | imemren;
        grant_d = dreq & ~(imemren & last_d);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_req)   state_nx = ACC;
            ACC:     if (ram_ready) state_nx = HIT;
            HIT:                    state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Registered outputs and per-access bookkeeping.
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            ihit      <= 1'b0;
            dhit      <= 1'b0;
            ram_ren   <= 1'b0;
            ram_wen   <= 1'b0;
            err       <= 1'b0;
            last_d    <= 1'b0;
            src_d     <= 1'b0;
            src_wr    <= 1'b0;
            wd_cnt    <= '0;
            imemload  <= '0;
            dmemload  <= '0;
            ram_addr  <= '0;
            ram_store <= '0;
        end else begin
            // Hits are single-cycle: anything set below lasts only for HIT.
            ihit <= 1'b0;
            dhit <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        src_d    <= grant_d;
                        src_wr   <= grant_d & dmemwen;
                        last_d   <= grant_d;
                        ram_addr <= grant_d ? dmemaddr : imemaddr;
                        if (grant_d) begin
                            ram_store <= dmemstore;
                        end
                        ram_wen  <= grant_d & dmemwen;
                        ram_ren  <= ~(grant_d & dmemwen);
                        wd_cnt   <= '0;
                    end
                end
                ACC: begin
                    if (ram_ready) begin
                        ram_ren <= 1'b0;
                        ram_wen <= 1'b0;
                        // The access always completes; the hit is only
                        // reported if the requester is still asking for it.
                        if (src_d) begin
                            if (!src_wr) begin
                                dmemload <= ram_load;
                            end
                            dhit <= dreq;
                        end else begin
                            imemload <= ram_load;
                            ihit     <= imemren;
                        end
                    end else if (wd_cnt != CNT_W'(TIMEOUT)) begin
                        // Saturating count of unanswered ACC cycles.
                        wd_cnt <= wd_cnt + 1'b1;
                        if (wd_cnt == CNT_W'(TIMEOUT - 1)) begin
                            err <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
